bus_rr_arbiter: RTL and testbench
=================================

# bus_rr_arbiter

Round-robin arbiter and transfer sequencer for the shared data bus. Selects one of `DRIVERS` pending driver FIFOs, pops its head word, and delivers it in a single bus slot to the destination FIFO(s) named by the word's top 8 bits. Broadcast words go to every driver except the source. The block replaces per-driver bus contention with a single owner of the shared push/data lines and reports every completed or dropped transfer.

## Interface

- `DRIVERS`, 4, number of bus agents; range 2..16.
- `WIDTH`, 32, packet width. Bits [WIDTH-1:WIDTH-8] hold the destination ID; the remaining bits are payload.
- `BROADCAST`, 8'hFF, destination ID meaning all drivers.

- `clk_i` in 1, bus clock.
- `rst_ni` in 1, synchronous, active-low reset.
- `pndng_i` in DRIVERS, bit i high means driver FIFO i is not empty.
- `d_pop_i` in DRIVERS*WIDTH, head word of each FIFO. Slice i is [i*WIDTH +: WIDTH]; it is valid combinationally while `pndng_i[i]` is high.
- `pop_o` out DRIVERS, one-hot, 1-cycle pulse that pops the granted FIFO.
- `push_o` out DRIVERS, push strobes to the destination FIFOs.
- `d_push_o` out WIDTH, shared bus data.
- `gnt_o` out DRIVERS, one-hot index of the current bus owner; 0 when idle.
- `busy_o` out 1, high in GRANT and DELIVER.
- `err_o` out 1, 1-cycle pulse when a transfer is dropped.
- `xfer_cnt_o` out 16, count of completed transfers. Wraps 16'hFFFF to 0. Dropped transfers are not counted.

## Operation

- Registered FSM with states IDLE, GRANT, DELIVER.
- **Selection** (combinational, evaluated in IDLE and DELIVER):
  - Search `pndng_i` starting at index `last_q+1` mod DRIVERS.
  - The first set bit wins.
  - `last_q` resets to DRIVERS-1, so driver 0 has first priority out of reset.
- **IDLE**:
  - If any `pndng_i` bit is set: register the winner into `src_q`, go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**:
  - `pop_o[src_q]`=1, `gnt_o[src_q]`=1.
  - Latch `d_pop_i` slice `src_q` into `data_q`.
  - Set `last_q`←`src_q`.
  - Go to DELIVER.
- **DELIVER**:
  - `d_push_o`=`data_q`, `gnt_o` held at the source.
  - Destination `dst` = `data_q[WIDTH-1 -: 8]`. Push decode:
    - `dst`==BROADCAST: `push_o` = all ones except bit `src_q`. Counts as 1 transfer.
    - `dst`<DRIVERS and `dst`!=`src_q`: `push_o[dst]`=1.
    - `dst`>=DRIVERS (and not BROADCAST), or `dst`==`src_q`: `push_o`=0 and `err_o`=1.
  - Next state: if any `pndng_i` bit is set, register the new winner (search uses the updated `last_q`) and go to GRANT; otherwise go to IDLE.
- Destination FIFO full/backpressure is not observed. Destination FIFOs are sized (`profundidad`) by the environment.
- Outside the states listed above, `pop_o`, `push_o` and `err_o` are 0 and `d_push_o` holds its last value.

## Timing

- All outputs are registered or decoded only from registered state. None depend combinationally on `pndng_i`.
- Reset values, on the edge where `rst_ni`=0:
  - State IDLE.
  - `pop_o`, `push_o`, `gnt_o`, `busy_o`, `err_o` = 0.
  - `d_push_o`=0, `xfer_cnt_o`=0.
  - `last_q`=DRIVERS-1, `src_q`=0, `data_q`=0.
- Latency from `pndng_i` rising in IDLE:
  - Pop is issued at cycle +1 (GRANT).
  - Push is issued at cycle +2 (DELIVER).
- Back-to-back throughput: 1 transfer per 2 cycles. DELIVER→GRANT has no idle cycle.
- `xfer_cnt_o` increments on the clock edge that ends a non-error DELIVER.
- Reset asserted mid-GRANT or mid-DELIVER: the in-flight word is discarded and no push occurs on or after that edge. A pop already issued is not replayed.
- Fairness: with all drivers pending continuously, the grant order is 0,1,…,DRIVERS-1,0,… Each driver waits at most 2·(DRIVERS−1) cycles between grants.
- `pndng_i` changing during GRANT has no effect on the current transfer.

## Test plan

1. **Single unicast.** DRIVERS=4. After reset, driver 1 pending with 32'h02000001.
   - Cycle +1: `pop_o`=4'b0010.
   - Cycle +2: `push_o`=4'b0100, `d_push_o`=32'h02000001.
   - Then IDLE, and `xfer_cnt_o`=1.
2. **Broadcast.** Driver 2 sends 32'hFF0000AA.
   - DELIVER: `push_o`=4'b1011.
   - `xfer_cnt_o` increments by 1.
3. **Round robin.** All four drivers pending continuously for 8 transfers.
   - Pops in order 0,1,2,3,0,1,2,3 on every other cycle.
   - `busy_o` stays high throughout.
4. **Invalid and self-addressed.**
   - Driver 0 sends 32'h07000000: `err_o` pulses, `push_o`=0, count unchanged.
   - Driver 3 sends 32'h03000000: same response.
5. **Reset mid-transfer.** Assert `rst_ni`=0 during GRANT of driver 1.
   - No push occurs; all outputs return to their reset values.
   - After release, driver 0 wins first if pending.
6. **Counter wrap.** Preload 65535 transfers (or force the counter).
   - The next good transfer makes `xfer_cnt_o`=0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_rr_arbiter
// Purpose  : Round-robin arbiter and transfer sequencer for the shared data
//            bus. Picks one pending driver FIFO, pops its head word, and
//            pushes it to the destination FIFO(s) in a single bus slot.
//            Unicast, broadcast (all but source) and dropped transfers are
//            supported. A counter tracks completed transfers.
// Ports    : clk_i      - bus clock
//            rst_ni     - synchronous active-low reset
//            pndng_i    - per-driver "FIFO not empty"
//            d_pop_i    - head word of every driver FIFO, packed
//            pop_o      - one-hot pop pulse to the granted FIFO
//            push_o     - push strobes to destination FIFOs
//            d_push_o   - shared bus data
//            gnt_o      - one-hot current bus owner (0 when idle)
//            busy_o     - high while a transfer is in progress
//            err_o      - pulse when a transfer is dropped
//            xfer_cnt_o - completed transfer count (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module bus_rr_arbiter #(
  parameter int         DRIVERS   = 4,
  parameter int         WIDTH     = 32,
  parameter logic [7:0] BROADCAST = 8'hFF
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DRIVERS-1:0]         pndng_i,
  input  logic [DRIVERS*WIDTH-1:0]   d_pop_i,
  output logic [DRIVERS-1:0]         pop_o,
  output logic [DRIVERS-1:0]         push_o,
  output logic [WIDTH-1:0]           d_push_o,
  output logic [DRIVERS-1:0]         gnt_o,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [15:0]                xfer_cnt_o
);

  localparam int IDX_W = (DRIVERS > 1) ? $clog2(DRIVERS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     last_q;
  logic [IDX_W-1:0]     src_q;
  logic [WIDTH-1:0]     data_q;
  logic [DRIVERS-1:0]   pop_q;
  logic [DRIVERS-1:0]   push_q;
  logic [DRIVERS-1:0]   gnt_q;
  logic                 busy_q;
  logic                 err_q;
  logic [15:0]          xfer_cnt;

  // Unpack the head words so the source can be selected by index.
  logic [WIDTH-1:0] head [DRIVERS];

  for (genvar g = 0; g < DRIVERS; g++) begin : g_unpack
    assign head[g] = d_pop_i[g*WIDTH +: WIDTH];
  end

  function automatic logic [DRIVERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [DRIVERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search starting just after the last served driver.
  logic [IDX_W-1:0] win;
  logic             found;
  logic             any_pndng;

  always_comb begin
    logic [IDX_W:0] cand;
    win   = last_q;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= DRIVERS; i++) begin
      cand = {1'b0, last_q} + (IDX_W + 1)'(i);
      if (int'(cand) >= DRIVERS) begin
        cand = cand - (IDX_W + 1)'(DRIVERS);
      end
      if (!found && pndng_i[cand[IDX_W-1:0]]) begin
        win   = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
    any_pndng = |pndng_i;
  end

  // Destination decode of the word being popped this GRANT cycle; the
  // result is registered so push/err appear during DELIVER.
  logic [WIDTH-1:0]   cur_word;
  logic [7:0]         dst;
  logic [DRIVERS-1:0] dec_push;
  logic               dec_err;

  always_comb begin
    cur_word = head[src_q];
    dst      = cur_word[WIDTH-1 -: 8];
    dec_push = '0;
    dec_err  = 1'b0;
    if (dst == BROADCAST) begin
      dec_push = ~onehot(src_q);
    end else if ((int'(dst) < DRIVERS) &&
                 (dst != {{(8 - IDX_W){1'b0}}, src_q})) begin
      dec_push = onehot(dst[IDX_W-1:0]);
    end else begin
      dec_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      last_q   <= IDX_W'(DRIVERS - 1);
      src_q    <= '0;
      data_q   <= '0;
      pop_q    <= '0;
      push_q   <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          push_q <= '0;
          err_q  <= 1'b0;
          if (any_pndng) begin
            src_q  <= win;
            pop_q  <= onehot(win);
            gnt_q  <= onehot(win);
            busy_q <= 1'b1;
            state  <= GRANT;
          end else begin
            pop_q  <= '0;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end

        GRANT: begin
          pop_q  <= '0;
          data_q <= cur_word;
          last_q <= src_q;
          push_q <= dec_push;
          err_q  <= dec_err;
          state  <= DELIVER;
        end

        DELIVER: begin
          push_q <= '0;
          err_q  <= 1'b0;
          if (!err_q) begin
            xfer_cnt <= xfer_cnt + 16'd1;
          end
          // last_q already holds src_q here, so the search continues
          // from the driver just served.
          if (any_pndng) begin
            src_q <= win;
            pop_q <= onehot(win);
            gnt_q <= onehot(win);
            state <= GRANT;
          end else begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          pop_q  <= '0;
          push_q <= '0;
          gnt_q  <= '0;
          busy_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign pop_o      = pop_q;
  assign push_o     = push_q;
  assign d_push_o   = data_q;
  assign gnt_o      = gnt_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign xfer_cnt_o = xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rr_arbiter
// Purpose  : Self-checking bench for bus_rr_arbiter (DRIVERS=4, WIDTH=32).
//            Table of single transfers plus hand sequences for round robin,
//            reset during GRANT and counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_rr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   pndng;
  logic [127:0] d_pop;
  logic [3:0]   pop;
  logic [3:0]   push;
  logic [31:0]  d_push;
  logic [3:0]   gnt;
  logic         busy;
  logic         err;
  logic [15:0]  xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] cnt_model;

  bus_rr_arbiter #(
    .DRIVERS   (4),
    .WIDTH     (32),
    .BROADCAST (8'hFF)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pndng_i    (pndng),
    .d_pop_i    (d_pop),
    .pop_o      (pop),
    .push_o     (push),
    .d_push_o   (d_push),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .err_o      (err),
    .xfer_cnt_o (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] word;
    logic [3:0]  exp_pop;
    logic [3:0]  exp_push;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Called at a negedge with the DUT idle: one transfer from one driver.
  task automatic run_xfer(input int src, input logic [31:0] word,
                          input logic [3:0] e_pop, input logic [3:0] e_push,
                          input logic e_err);
    d_pop[src*32 +: 32] = word;
    pndng = oh(src);
    @(negedge clk);                       // GRANT
    check("grant_pop", {28'd0, pop}, {28'd0, e_pop});
    check("grant_gnt", {28'd0, gnt}, {28'd0, e_pop});
    check("grant_push", {28'd0, push}, 32'd0);
    pndng = 4'b0000;
    @(negedge clk);                       // DELIVER
    check("dlv_push", {28'd0, push}, {28'd0, e_push});
    check("dlv_err", {31'd0, err}, {31'd0, e_err});
    check("dlv_pop", {28'd0, pop}, 32'd0);
    check("dlv_data", d_push, word);
    check("dlv_busy", {31'd0, busy}, 32'd1);
    if (!e_err) cnt_model = cnt_model + 16'd1;
    @(negedge clk);                       // back in IDLE
    check("idle_cnt", {16'd0, xfer_cnt}, {16'd0, cnt_model});
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_gnt", {28'd0, gnt}, 32'd0);
    check("idle_push", {28'd0, push}, 32'd0);
    check("idle_err", {31'd0, err}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pop"},  {28'd0, pop},  32'd0);
    check({tag, "_push"}, {28'd0, push}, 32'd0);
    check({tag, "_gnt"},  {28'd0, gnt},  32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_err"},  {31'd0, err},  32'd0);
    check({tag, "_data"}, d_push, 32'd0);
    check({tag, "_cnt"},  {16'd0, xfer_cnt}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{src: 1, word: 32'h02000001, exp_pop: 4'b0010, exp_push: 4'b0100, exp_err: 1'b0};
    vecs[1] = '{src: 2, word: 32'hFF0000AA, exp_pop: 4'b0100, exp_push: 4'b1011, exp_err: 1'b0};
    vecs[2] = '{src: 0, word: 32'h07000000, exp_pop: 4'b0001, exp_push: 4'b0000, exp_err: 1'b1};
    vecs[3] = '{src: 3, word: 32'h03000000, exp_pop: 4'b1000, exp_push: 4'b0000, exp_err: 1'b1};
    vecs[4] = '{src: 0, word: 32'h03000055, exp_pop: 4'b0001, exp_push: 4'b1000, exp_err: 1'b0};
    vecs[5] = '{src: 3, word: 32'h00ABCDEF, exp_pop: 4'b1000, exp_push: 4'b0001, exp_err: 1'b0};

    rst_n     = 1'b0;
    pndng     = 4'b0000;
    d_pop     = '0;
    cnt_model = 16'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single-driver transfers: unicast, broadcast, invalid, self-addressed.
    for (int v = 0; v < 6; v++) begin
      run_xfer(vecs[v].src, vecs[v].word, vecs[v].exp_pop,
               vecs[v].exp_push, vecs[v].exp_err);
    end

    // Round robin from a fresh reset, all drivers pending.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    cnt_model = 16'd0;
    for (int i = 0; i < 4; i++) begin
      d_pop[i*32 +: 32] = {8'((i + 1) % 4), 24'(i)};
    end
    pndng = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("rr_busy", {31'd0, busy}, 32'd1);
      if ((k % 2) == 0) begin
        check("rr_pop", {28'd0, pop}, {28'd0, oh((k / 2) % 4)});
        if (k == 14) pndng = 4'b0000;
      end else begin
        check("rr_pop_idle", {28'd0, pop}, 32'd0);
        check("rr_push", {28'd0, push}, {28'd0, oh(((k / 2) + 1) % 4)});
        cnt_model = cnt_model + 16'd1;
      end
    end
    @(negedge clk);
    check("rr_cnt", {16'd0, xfer_cnt}, {16'd0, cnt_model});
    check("rr_idle_busy", {31'd0, busy}, 32'd0);

    // Reset asserted during GRANT of driver 1.
    d_pop[32 +: 32] = 32'h02000077;
    pndng = 4'b0010;
    @(negedge clk);
    check("mid_pop", {28'd0, pop}, 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(negedge clk);
    check("mid_rst_push2", {28'd0, push}, 32'd0);
    rst_n     = 1'b1;
    cnt_model = 16'd0;
    d_pop[0 +: 32] = 32'h01000000;
    pndng = 4'b0011;
    @(negedge clk);
    check("post_rst_pop", {28'd0, pop}, 32'h1);
    pndng = 4'b0000;
    @(negedge clk);
    check("post_rst_push", {28'd0, push}, 32'h2);
    cnt_model = cnt_model + 16'd1;
    @(negedge clk);
    check("post_rst_cnt", {16'd0, xfer_cnt}, {16'd0, cnt_model});

    // Counter wrap: preload the counter, then one good transfer.
    force dut.xfer_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_cnt;
    cnt_model = 16'hFFFF;
    @(negedge clk);
    check("wrap_pre", {16'd0, xfer_cnt}, 32'h0000FFFF);
    run_xfer(1, 32'h02000001, 4'b0010, 4'b0100, 1'b0);
    check("wrap_zero", {16'd0, xfer_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
